// File: rtl/delay_ctrl_2_2.sv
// delay_ctrl_2_2: upstream delay stage of a 2x2 stride commutator.
// Lane 0 is passed through one register; lane 1 is delayed DEPTH valid beats
// through a beat-advanced shift line. A beat counter produces the switch
// select (DEPTH beats straight, DEPTH beats cross) and a start-of-period pulse,
// both aligned with the data presented on the outputs.
module delay_ctrl_2_2 #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inValid,
  input  logic [DATA_WIDTH-1:0] inData_0,
  input  logic [DATA_WIDTH-1:0] inData_1,
  output logic                  outValid,
  output logic [DATA_WIDTH-1:0] outData_0,
  output logic [DATA_WIDTH-1:0] outData_1,
  output logic                  ctrl,
  output logic                  outSof
);

  // Counter spans one full ctrl period (2*DEPTH beats); its MSB is the select.
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic [DATA_WIDTH-1:0] line_q [DEPTH];
  logic [DATA_WIDTH-1:0] line_d [DEPTH];
  logic                  valid_q, valid_d;
  logic                  ctrl_q,  ctrl_d;
  logic                  sof_q,   sof_d;
  logic [DATA_WIDTH-1:0] data0_q, data0_d;
  logic [DATA_WIDTH-1:0] data1_q, data1_d;

  // Next-state: everything advances on a beat, otherwise holds (valid/sof drop).
  always_comb begin
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    sof_d   = 1'b0;
    ctrl_d  = ctrl_q;
    data0_d = data0_q;
    data1_d = data1_q;
    for (int i = 0; i < DEPTH; i++) begin
      line_d[i] = line_q[i];
    end
    if (inValid) begin
      valid_d   = 1'b1;
      data0_d   = inData_0;
      data1_d   = line_q[DEPTH-1];
      ctrl_d    = cnt_q[CNT_W-1];
      sof_d     = (cnt_q == {CNT_W{1'b0}});
      cnt_d     = cnt_q + CNT_W'(1);
      line_d[0] = inData_1;
      for (int i = 1; i < DEPTH; i++) begin
        line_d[i] = line_q[i-1];
      end
    end else begin
      valid_d = 1'b0;
      sof_d   = 1'b0;
    end
  end

  // State and output registers; asynchronous reset clears the whole line too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= {CNT_W{1'b0}};
      valid_q <= 1'b0;
      ctrl_q  <= 1'b0;
      sof_q   <= 1'b0;
      data0_q <= {DATA_WIDTH{1'b0}};
      data1_q <= {DATA_WIDTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        line_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      sof_q   <= sof_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      for (int i = 0; i < DEPTH; i++) begin
        line_q[i] <= line_d[i];
      end
    end
  end

  assign outValid  = valid_q;
  assign outData_0 = data0_q;
  assign outData_1 = data1_q;
  assign ctrl      = ctrl_q;
  assign outSof    = sof_q;

endmodule

// File: tb/tb_delay_ctrl_2_2.sv
// Bench for delay_ctrl_2_2: four instances (DEPTH 4, 1, 8, 2) share one
// stimulus stream and are compared against a beat-indexed reference model.
module tb_delay_ctrl_2_2;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic [31:0] inData_0;
  logic [31:0] inData_1;

  logic [3:0][31:0] o0;
  logic [3:0][31:0] o1;
  logic [3:0]       ov;
  logic [3:0]       ct;
  logic [3:0]       sf;

  int dep [4] = '{4, 1, 8, 2};

  // Reference model state: beats since reset and lane-1 history.
  int          k;
  logic [31:0] hist [$];
  logic [31:0] e_d0 [4];
  logic [31:0] e_d1 [4];
  logic        e_v  [4];
  logic        e_ct [4];
  logic        e_sf [4];

  int ntests;
  int nfail;

  // DEPTH=1 directed expectations
  logic [31:0] x1_d1 [4] = '{32'd0, 32'd10, 32'd11, 32'd12};
  logic        x1_ct [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic        x1_sf [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  // DEPTH=2 switch expectations for beats 4..7
  logic [31:0] sw_top_x [4] = '{32'd8, 32'd9, 32'd12, 32'd13};
  logic [31:0] sw_bot_x [4] = '{32'd6, 32'd7, 32'd10, 32'd11};

  logic [31:0] sw_top;
  logic [31:0] sw_bot;
  assign sw_top = ct[3] ? o1[3] : o0[3];
  assign sw_bot = ct[3] ? o0[3] : o1[3];

  delay_ctrl_2_2 #(.DATA_WIDTH(32), .DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst), .inValid(inValid), .inData_0(inData_0), .inData_1(inData_1),
    .outValid(ov[0]), .outData_0(o0[0]), .outData_1(o1[0]), .ctrl(ct[0]), .outSof(sf[0]));
  delay_ctrl_2_2 #(.DATA_WIDTH(32), .DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst), .inValid(inValid), .inData_0(inData_0), .inData_1(inData_1),
    .outValid(ov[1]), .outData_0(o0[1]), .outData_1(o1[1]), .ctrl(ct[1]), .outSof(sf[1]));
  delay_ctrl_2_2 #(.DATA_WIDTH(32), .DEPTH(8)) u_d8 (
    .clk(clk), .rst(rst), .inValid(inValid), .inData_0(inData_0), .inData_1(inData_1),
    .outValid(ov[2]), .outData_0(o0[2]), .outData_1(o1[2]), .ctrl(ct[2]), .outSof(sf[2]));
  delay_ctrl_2_2 #(.DATA_WIDTH(32), .DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .inValid(inValid), .inData_0(inData_0), .inData_1(inData_1),
    .outValid(ov[3]), .outData_0(o0[3]), .outData_1(o1[3]), .ctrl(ct[3]), .outSof(sf[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp_v);
    ntests++;
    assert (obs === exp_v) else begin
      nfail++;
      $error("FAIL %s D=%0d observed=%0h expected=%0h", tag, d, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    k = 0;
    hist.delete();
    for (int i = 0; i < 4; i++) begin
      e_d0[i] = 32'd0; e_d1[i] = 32'd0;
      e_v[i] = 1'b0; e_ct[i] = 1'b0; e_sf[i] = 1'b0;
    end
  endtask

  // Expected outputs for beat k follow directly from the beat index.
  task automatic model_edge(input logic v, input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 4; i++) begin
      if (v) begin
        e_v[i]  = 1'b1;
        e_d0[i] = a;
        e_d1[i] = (k >= dep[i]) ? hist[k - dep[i]] : 32'd0;
        e_ct[i] = ((k / dep[i]) % 2) == 1;
        e_sf[i] = (k % (2 * dep[i])) == 0;
      end else begin
        e_v[i]  = 1'b0;
        e_sf[i] = 1'b0;
      end
    end
    if (v) begin
      hist.push_back(b);
      k++;
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk({tag, ".outValid"},  dep[i], {31'd0, ov[i]}, {31'd0, e_v[i]});
      chk({tag, ".outData_0"}, dep[i], o0[i], e_d0[i]);
      chk({tag, ".outData_1"}, dep[i], o1[i], e_d1[i]);
      chk({tag, ".ctrl"},      dep[i], {31'd0, ct[i]}, {31'd0, e_ct[i]});
      chk({tag, ".outSof"},    dep[i], {31'd0, sf[i]}, {31'd0, e_sf[i]});
    end
  endtask

  task automatic cycle(input string tag, input logic v, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    inValid = v; inData_0 = a; inData_1 = b;
    @(posedge clk);
    model_edge(v, a, b);
    #1;
    check_all(tag);
  endtask

  // Assert reset between clock edges and check outputs clear before the next edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b1;
    inValid = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    ntests = 0; nfail = 0;
    rst = 1'b0; inValid = 1'b0; inData_0 = 32'd0; inData_1 = 32'd0;
    model_reset();
    #2;
    rst = 1'b1;
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Continuous stream
    for (int j = 0; j < 16; j++) cycle("cont", 1'b1, 32'(j), 32'(100 + j));

    // Bubbles on every third cycle
    async_reset("rst_bub");
    begin
      int b = 0;
      for (int c = 0; c < 24; c++) begin
        if (c % 3 == 2) cycle("bub", 1'b0, 32'hdead0000, 32'hbeef0000);
        else begin
          cycle("bub", 1'b1, 32'(b), 32'(100 + b));
          b++;
        end
      end
    end

    // Reset mid-stream after beat 6
    async_reset("rst_pre");
    for (int j = 0; j < 7; j++) cycle("pre", 1'b1, 32'(300 + j), 32'(400 + j));
    async_reset("rst_mid");
    for (int j = 0; j < 12; j++) cycle("post", 1'b1, 32'(j), 32'(200 + j));

    // DEPTH=1 directed
    async_reset("rst_d1");
    for (int j = 0; j < 4; j++) begin
      cycle("d1", 1'b1, 32'(j), 32'(10 + j));
      chk("d1x.outData_1", 1, o1[1], x1_d1[j]);
      chk("d1x.ctrl", 1, {31'd0, ct[1]}, {31'd0, x1_ct[j]});
      chk("d1x.outSof", 1, {31'd0, sf[1]}, {31'd0, x1_sf[j]});
    end

    // Wrap check (DEPTH=8 sees two full periods and a bit)
    async_reset("rst_wrap");
    for (int j = 0; j < 40; j++) cycle("wrap", 1'b1, 32'(j), 32'(500 + j));

    // Switch integration with DEPTH=2
    async_reset("rst_sw");
    for (int j = 0; j < 8; j++) begin
      cycle("sw", 1'b1, (j < 4) ? 32'(j) : 32'(j + 4), (j < 4) ? 32'(j + 4) : 32'(j + 8));
      if (j >= 4) begin
        chk("sw.top", 2, sw_top, sw_top_x[j - 4]);
        chk("sw.bot", 2, sw_bot, sw_bot_x[j - 4]);
      end
    end

    // Randomized traffic with occasional resets
    async_reset("rst_rand");
    for (int j = 0; j < 300; j++) begin
      if ($urandom_range(0, 79) == 0) async_reset("rst_r");
      cycle("rand", ($urandom_range(0, 3) != 0), $urandom, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
